// File: rtl/lsu.sv
// Load/store unit: one request at a time, byte/half/word/double sizing, alignment checks,
// load extension and read-modify-write for sub-doubleword stores over a doubleword memory port.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_raddr,
  input  logic [63:0] mem_rdata,
  output logic [31:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic        mem_wen
);

  typedef enum logic [2:0] {StIdle, StLoad, StMerge, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] line_q, line_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic [5:0]  bit_off;
  logic [63:0] shifted;
  logic [63:0] load_ext;
  logic [63:0] size_mask;
  logic [63:0] merge_mask;
  logic [63:0] merged;

  always_comb begin
    unique case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign bit_off = {addr_q[2:0], 3'b000};
  assign shifted = mem_rdata >> bit_off;

  always_comb begin
    unique case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    unique case (size_q)
      2'd0:    size_mask = 64'h0000_0000_0000_00ff;
      2'd1:    size_mask = 64'h0000_0000_0000_ffff;
      2'd2:    size_mask = 64'h0000_0000_ffff_ffff;
      default: size_mask = 64'hffff_ffff_ffff_ffff;
    endcase
  end

  // Store bytes land at [off, off+nbytes); everything else keeps the current memory contents.
  assign merge_mask = size_mask << bit_off;
  assign merged     = (mem_rdata & ~merge_mask) | ((wdata_q << bit_off) & merge_mask);

  assign mem_raddr  = {3'b000, addr_q[31:3]};
  assign mem_waddr  = {3'b000, addr_q[31:3]};
  assign mem_wdata  = line_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wen    = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = !rst;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wen_d   = req_wen;
          wdata_d = req_wdata;
          rdata_d = 64'd0;
          err_d   = misaligned;
          if (misaligned) begin
            state_d = StResp;
          end else if (!req_wen) begin
            state_d = StLoad;
          end else if (req_size == 2'd3) begin
            line_d  = req_wdata;
            state_d = StWrite;
          end else begin
            state_d = StMerge;
          end
        end
      end
      StLoad: begin
        rdata_d = load_ext;
        state_d = StResp;
      end
      StMerge: begin
        line_d  = merged;
        state_d = StWrite;
      end
      StWrite: begin
        mem_wen = !rst;
        state_d = StResp;
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wen_q   <= 1'b0;
      wdata_q <= 64'd0;
      line_q  <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small doubleword memory model on the data port.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic        mem_wen;

  logic [63:0] mem [16];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wen      (mem_wen)
  );

  assign mem_rdata = mem[mem_raddr[3:0]];

  // Memory preload uses its own init strobe so a DUT reset never masks a stray write.
  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
      mem[2] <= 64'h1122_3344_8899_aabb;
      mem[3] <= 64'h0102_0304_0506_0708;
    end else if (mem_wen) begin
      mem[mem_waddr[3:0]] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [63:0] d);
    req_valid    = 1'b1;
    req_wen      = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 64'd0; resp_ready = 1'b0;
    tick(); tick();
    check("ready_in_reset", {63'd0, req_ready}, 64'd0);
    check("wen_in_reset", {63'd0, mem_wen}, 64'd0);
    init = 1'b0; rst = 1'b0;
    #1;
    check("reset_req_ready", {63'd0, req_ready}, 64'd1);
    check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("reset_resp_rdata", resp_rdata, 64'd0);
    check("reset_resp_err", {63'd0, resp_err}, 64'd0);

    // Signed W load at 0x10
    issue(1'b0, 2'd2, 1'b0, 32'h10, 64'd0);
    check("lw_t1_valid", {63'd0, resp_valid}, 64'd0);
    check("lw_t1_raddr", {32'd0, mem_raddr}, 64'd2);
    check("lw_t1_ready", {63'd0, req_ready}, 64'd0);
    tick();
    check("lw_t2_valid", {63'd0, resp_valid}, 64'd1);
    check("lw_rdata", resp_rdata, 64'hffff_ffff_8899_aabb);
    check("lw_err", {63'd0, resp_err}, 64'd0);
    consume();

    // Unsigned W load at 0x10
    issue(1'b0, 2'd2, 1'b1, 32'h10, 64'd0);
    tick();
    check("lwu_valid", {63'd0, resp_valid}, 64'd1);
    check("lwu_rdata", resp_rdata, 64'h0000_0000_8899_aabb);
    consume();

    // Signed B load at 0x17
    issue(1'b0, 2'd0, 1'b0, 32'h17, 64'd0);
    tick();
    check("lb_rdata", resp_rdata, 64'h0000_0000_0000_0011);
    consume();

    // Byte RMW store at 0x13
    issue(1'b1, 2'd0, 1'b0, 32'h13, 64'hffff_ffff_ffff_ff5a);
    check("sb_t1_wen", {63'd0, mem_wen}, 64'd0);
    check("sb_t1_valid", {63'd0, resp_valid}, 64'd0);
    tick();
    check("sb_t2_wen", {63'd0, mem_wen}, 64'd1);
    check("sb_t2_waddr", {32'd0, mem_waddr}, 64'd2);
    check("sb_t2_wdata", mem_wdata, 64'h1122_3344_5a99_aabb);
    check("sb_t2_valid", {63'd0, resp_valid}, 64'd0);
    tick();
    check("sb_t3_wen", {63'd0, mem_wen}, 64'd0);
    check("sb_t3_valid", {63'd0, resp_valid}, 64'd1);
    check("sb_rdata", resp_rdata, 64'd0);
    check("sb_err", {63'd0, resp_err}, 64'd0);
    check("sb_mem2", mem[2], 64'h1122_3344_5a99_aabb);
    consume();

    // Misaligned H load at 0x11
    issue(1'b0, 2'd1, 1'b0, 32'h11, 64'd0);
    check("mis_lh_valid", {63'd0, resp_valid}, 64'd1);
    check("mis_lh_err", {63'd0, resp_err}, 64'd1);
    check("mis_lh_rdata", resp_rdata, 64'd0);
    check("mis_lh_wen", {63'd0, mem_wen}, 64'd0);
    consume();

    // Misaligned D store at 0x14
    issue(1'b1, 2'd3, 1'b0, 32'h14, 64'hdead_dead_dead_dead);
    check("mis_sd_valid", {63'd0, resp_valid}, 64'd1);
    check("mis_sd_err", {63'd0, resp_err}, 64'd1);
    check("mis_sd_wen", {63'd0, mem_wen}, 64'd0);
    consume();
    check("mis_mem2", mem[2], 64'h1122_3344_5a99_aabb);

    // Backpressure: B unsigned load at 0x10 with a W load pending
    issue(1'b0, 2'd0, 1'b1, 32'h10, 64'd0);
    tick();
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b1;
    req_addr = 32'h14; req_wdata = 64'd0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {63'd0, resp_valid}, 64'd1);
      check("bp_rdata", resp_rdata, 64'h0000_0000_0000_00bb);
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      tick();
    end
    consume();
    check("bp_idle_ready", {63'd0, req_ready}, 64'd1);
    check("bp_idle_valid", {63'd0, resp_valid}, 64'd0);
    tick();
    req_valid = 1'b0;
    check("bp_accepted", {63'd0, req_ready}, 64'd0);
    tick();
    check("bp_next_valid", {63'd0, resp_valid}, 64'd1);
    check("bp_next_rdata", resp_rdata, 64'h0000_0000_1122_3344);
    consume();

    // Reset during WRITE of a W store at 0x18
    issue(1'b1, 2'd2, 1'b0, 32'h18, 64'h0000_0000_1234_5678);
    check("rst_t1_wen", {63'd0, mem_wen}, 64'd0);
    tick();
    check("rst_t2_wen_pre", {63'd0, mem_wen}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_t2_wen_gated", {63'd0, mem_wen}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_after_ready", {63'd0, req_ready}, 64'd1);
    check("rst_after_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_mem3", mem[3], 64'h0102_0304_0506_0708);

    // D store at 0x20 then signed H load at 0x22
    issue(1'b1, 2'd3, 1'b0, 32'h20, 64'hdead_beef_cafe_f00d);
    check("sd_t1_wen", {63'd0, mem_wen}, 64'd1);
    check("sd_t1_wdata", mem_wdata, 64'hdead_beef_cafe_f00d);
    check("sd_t1_waddr", {32'd0, mem_waddr}, 64'd4);
    tick();
    check("sd_t2_valid", {63'd0, resp_valid}, 64'd1);
    check("sd_t2_wen", {63'd0, mem_wen}, 64'd0);
    consume();
    issue(1'b0, 2'd1, 1'b0, 32'h22, 64'd0);
    tick();
    check("lh_valid", {63'd0, resp_valid}, 64'd1);
    check("lh_rdata", resp_rdata, 64'hffff_ffff_ffff_cafe);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
